// File: rtl/countdown_timer.sv
// Remaining-time counter: holds a track duration as BCD digits (m0, s1, s0),
// counts down on 1 Hz ticks while running, applies seek skips and flags expiry.
module countdown_timer #(
   parameter int DIGIT_W     = 6,
   parameter int MAX_MINUTES = 9
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               count,
   input  logic               load,
   input  logic [DIGIT_W-1:0] load_m0,
   input  logic [DIGIT_W-1:0] load_s1,
   input  logic [DIGIT_W-1:0] load_s0,
   input  logic               skip,
   input  logic [5:0]         skip_secs,
   output logic [DIGIT_W-1:0] seconds0,
   output logic [DIGIT_W-1:0] seconds1,
   output logic [DIGIT_W-1:0] minutes0,
   output logic               running,
   output logic               zero,
   output logic               done,
   output logic               load_err
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_RUN     = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [DIGIT_W-1:0] m0_q, m0_d;
   logic [DIGIT_W-1:0] s1_q, s1_d;
   logic [DIGIT_W-1:0] s0_q, s0_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               load_ok_s;
   logic               load_zero_s;
   logic               active_s;
   logic [6:0]         dec_s;
   logic [9:0]         t_cur_s;
   logic [9:0]         t_next_s;
   logic [9:0]         t_rem60_s;

   // Total seconds of a BCD duration; 9:59 is 599, so 10 bits never overflow.
   function automatic logic [9:0] to_secs(input logic [DIGIT_W-1:0] m,
                                          input logic [DIGIT_W-1:0] t,
                                          input logic [DIGIT_W-1:0] u);
      return (10'(m) * 10'd60) + (10'(t) * 10'd10) + 10'(u);
   endfunction

   // Next-state, next-digit and pulse computation.
   always_comb begin
      state_d     = state_q;
      m0_d        = m0_q;
      s1_d        = s1_q;
      s0_d        = s0_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      load_ok_s   = (load_s0 <= DIGIT_W'(9)) && (load_s1 <= DIGIT_W'(5)) &&
                    (load_m0 <= DIGIT_W'(MAX_MINUTES));
      load_zero_s = (load_m0 == '0) && (load_s1 == '0) && (load_s0 == '0);
      active_s    = (state_q == ST_ARMED) || (state_q == ST_RUN);
      dec_s       = (skip ? {1'b0, skip_secs} : 7'd0) +
                    ((tick && (state_q == ST_RUN)) ? 7'd1 : 7'd0);
      t_cur_s     = to_secs(m0_q, s1_q, s0_q);
      t_next_s    = (t_cur_s > 10'(dec_s)) ? (t_cur_s - 10'(dec_s)) : 10'd0;
      t_rem60_s   = t_next_s % 10'd60;

      if (load) begin
         // A load wins over skip/tick; a rejected load leaves everything alone.
         if (load_ok_s) begin
            m0_d    = load_m0;
            s1_d    = load_s1;
            s0_d    = load_s0;
            state_d = load_zero_s ? ST_IDLE : ST_ARMED;
         end else begin
            err_d = 1'b1;
         end
      end else if (active_s) begin
         m0_d = DIGIT_W'(t_next_s / 10'd60);
         s1_d = DIGIT_W'(t_rem60_s / 10'd10);
         s0_d = DIGIT_W'(t_rem60_s % 10'd10);
         if (t_next_s == 10'd0) begin
            state_d = ST_EXPIRED;
            done_d  = 1'b1;
         end else begin
            case (state_q)
               ST_ARMED: state_d = count ? ST_RUN : ST_ARMED;
               ST_RUN:   state_d = count ? ST_RUN : ST_ARMED;
               default:  state_d = state_q;
            endcase
         end
      end else begin
         state_d = state_q;
      end
   end

   // State, digit and pulse registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         m0_q    <= '0;
         s1_q    <= '0;
         s0_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m0_q    <= m0_d;
         s1_q    <= s1_d;
         s0_q    <= s0_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign minutes0 = m0_q;
   assign seconds1 = s1_q;
   assign seconds0 = s0_q;
   assign running  = (state_q == ST_RUN);
   assign zero     = (m0_q == '0) && (s1_q == '0) && (s0_q == '0);
   assign done     = done_q;
   assign load_err = err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized self-checking bench for countdown_timer against a seconds-based
// reference model of the remaining time and play mode.
module tb_countdown_timer;

   localparam int DW   = 6;
   localparam int MAXM = 9;

   localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_EXPIRED = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          tick = 1'b0, count = 1'b0, load = 1'b0, skip = 1'b0;
   logic [DW-1:0] load_m0 = '0, load_s1 = '0, load_s0 = '0;
   logic [5:0]    skip_secs = 6'd0;
   logic [DW-1:0] seconds0, seconds1, minutes0;
   logic          running, zero, done, load_err;

   int n_tests = 0;
   int n_fail  = 0;

   int rem = 0;
   int mode = M_IDLE;
   int exp_done = 0;
   int exp_err = 0;

   countdown_timer #(.DIGIT_W(DW), .MAX_MINUTES(MAXM)) dut (
      .clk(clk), .reset(reset), .tick(tick), .count(count), .load(load),
      .load_m0(load_m0), .load_s1(load_s1), .load_s0(load_s0),
      .skip(skip), .skip_secs(skip_secs),
      .seconds0(seconds0), .seconds1(seconds1), .minutes0(minutes0),
      .running(running), .zero(zero), .done(done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int expv);
      n_tests++;
      if (obs != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_m0"}, int'(minutes0), rem / 60);
      check({tag, "_s1"}, int'(seconds1), (rem % 60) / 10);
      check({tag, "_s0"}, int'(seconds0), rem % 10);
      check({tag, "_running"}, int'(running), (mode == M_RUN) ? 1 : 0);
      check({tag, "_zero"}, int'(zero), (rem == 0) ? 1 : 0);
      check({tag, "_done"}, int'(done), exp_done);
      check({tag, "_load_err"}, int'(load_err), exp_err);
   endtask

   task automatic model_reset();
      rem = 0; mode = M_IDLE; exp_done = 0; exp_err = 0;
   endtask

   // Spec rules in whole seconds: load wins, skip/tick subtract with saturation.
   task automatic model_step(input bit ld, input int lm, input int ls1, input int ls0,
                             input bit sk, input int ss, input bit tk, input bit cnt);
      int dec;
      exp_done = 0;
      exp_err  = 0;
      if (ld) begin
         if (ls0 > 9 || ls1 > 5 || lm > MAXM) exp_err = 1;
         else begin
            rem  = 60 * lm + 10 * ls1 + ls0;
            mode = (rem == 0) ? M_IDLE : M_ARMED;
         end
      end else if (mode == M_ARMED || mode == M_RUN) begin
         dec = (sk ? ss : 0) + ((tk && mode == M_RUN) ? 1 : 0);
         rem = (rem > dec) ? rem - dec : 0;
         if (rem == 0) begin
            mode = M_EXPIRED;
            exp_done = 1;
         end else mode = cnt ? M_RUN : M_ARMED;
      end
   endtask

   task automatic step(input string tag, input bit ld, input int lm, input int ls1,
                       input int ls0, input bit sk, input int ss, input bit tk,
                       input bit cnt);
      load = ld; load_m0 = DW'(lm); load_s1 = DW'(ls1); load_s0 = DW'(ls0);
      skip = sk; skip_secs = 6'(ss); tick = tk; count = cnt;
      @(posedge clk);
      model_step(ld, lm, ls1, ls0, sk, ss, tk, cnt);
      #1;
      check_all(tag);
      load = 1'b0; skip = 1'b0; tick = 1'b0;
   endtask

   task automatic mid_cycle_reset(input string tag);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   initial begin
      // Reset state, sampled while reset is held low
      #3;
      model_reset();
      check_all("reset");
      @(negedge clk);
      reset = 1'b1;
      #1;

      // 1: 2:35 then three ticks -> 2:32
      step("t1_load", 1'b1, 2, 3, 5, 1'b0, 0, 1'b0, 1'b1);
      step("t1_arm", 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step("t1_tick", 1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 1'b1);
      check("t1_value", int'(minutes0) * 100 + int'(seconds1) * 10 + int'(seconds0), 232);

      // 2: 1:00 borrow, then pause
      step("t2_load", 1'b1, 1, 0, 0, 1'b0, 0, 1'b0, 1'b1);
      step("t2_arm", 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1);
      step("t2_tick", 1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 1'b1);
      check("t2_borrow", int'(minutes0) * 100 + int'(seconds1) * 10 + int'(seconds0), 59);
      step("t2_pause", 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("t2_held", 1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 1'b0);

      // 3: 0:02 runs out; done exactly once
      step("t3_load", 1'b1, 0, 0, 2, 1'b0, 0, 1'b0, 1'b1);
      step("t3_arm", 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1);
      step("t3_tick1", 1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 1'b1);
      step("t3_tick2", 1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 1'b1);
      check("t3_done_pulse", int'(done), 1);
      for (int i = 0; i < 3; i++) step("t3_expired", 1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 1'b1);

      // 4: saturating skip while paused; skip plus tick together
      step("t4_load", 1'b1, 0, 4, 0, 1'b0, 0, 1'b0, 1'b0);
      step("t4_skip", 1'b0, 0, 0, 0, 1'b1, 45, 1'b0, 1'b0);
      check("t4_sat_done", int'(done), 1);
      step("t4_load2", 1'b1, 3, 1, 0, 1'b0, 0, 1'b0, 1'b1);
      step("t4_arm", 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1);
      step("t4_skiptick", 1'b0, 0, 0, 0, 1'b1, 20, 1'b1, 1'b1);
      check("t4_value", int'(minutes0) * 100 + int'(seconds1) * 10 + int'(seconds0), 249);

      // 5: rejected loads, then load with a tick in the same cycle
      step("t5_bad_s0", 1'b1, 1, 1, 10, 1'b0, 0, 1'b1, 1'b1);
      step("t5_bad_m0", 1'b1, MAXM + 1, 0, 0, 1'b0, 0, 1'b0, 1'b1);
      step("t5_bad_s1", 1'b1, 0, 6, 0, 1'b1, 5, 1'b0, 1'b1);
      step("t5_after", 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1);
      step("t5_load_tick", 1'b1, 4, 1, 7, 1'b1, 9, 1'b1, 1'b1);
      check("t5_value", int'(minutes0) * 100 + int'(seconds1) * 10 + int'(seconds0), 417);

      // 6: asynchronous reset while running, then ticks do nothing
      step("t6_arm", 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1);
      check("t6_running", int'(running), 1);
      mid_cycle_reset("t6_reset");
      for (int i = 0; i < 3; i++) step("t6_idle", 1'b0, 0, 0, 0, 1'b1, 3, 1'b1, 1'b1);

      // Randomized phase
      for (int n = 0; n < 3000; n++) begin
         bit ld, sk, tk, cnt;
         int lm, ls1, ls0, ss;
         ld  = ($urandom_range(0, 15) == 0);
         sk  = ($urandom_range(0, 7) == 0);
         tk  = ($urandom_range(0, 2) == 0);
         cnt = ($urandom_range(0, 9) != 0) ? count : ~count;
         if ($urandom_range(0, 5) == 0) begin
            lm = $urandom_range(0, 12); ls1 = $urandom_range(0, 8); ls0 = $urandom_range(0, 12);
         end else begin
            lm = $urandom_range(0, MAXM); ls1 = $urandom_range(0, 5); ls0 = $urandom_range(0, 9);
         end
         ss = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 5);
         step("rand", ld, lm, ls1, ls0, sk, ss, tk, cnt);
         if ($urandom_range(0, 499) == 0) mid_cycle_reset("rand_reset");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
